// File: rtl/br_resolve_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// br_resolve_ctrl_pkg
// Shared types for the branch-resolution controller and its update queue.
//   word_t       : 32-bit machine word (PCs, targets, counters)
//   br_upd_t     : one predictor write {index, tag, target, taken}
//   brc_state_t  : controller state (INIT sweep, RUN)
// The index field is sized for the widest supported predictor. Narrower
// configurations zero-extend into it and truncate on the way out.
// ---------------------------------------------------------------------------
package br_resolve_ctrl_pkg;

    typedef logic [31:0] word_t;

    localparam int BRC_IDX_W_MAX = 8;

    typedef struct packed {
        logic [BRC_IDX_W_MAX-1:0] index;
        word_t                    tag;
        word_t                    target;
        logic                     taken;
    } br_upd_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } brc_state_t;

    // Sequential fall-through address, wrapping at 32 bits.
    function automatic word_t brc_fallthrough(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/br_resolve_ctrl_if.sv
// ---------------------------------------------------------------------------
// br_resolve_ctrl_if
// Bundles the EX resolution inputs, predictor write port and status outputs
// of br_resolve_ctrl.
//   slave  : controller view (EX + upd_ready in, everything else out)
//   master : environment view (EX stage, predictor, hazard unit, fetch)
// ---------------------------------------------------------------------------
interface br_resolve_ctrl_if
    import br_resolve_ctrl_pkg::*;
#(
    parameter int IDX_W = 2
) ();

    logic             ex_valid;
    word_t            ex_pc;
    logic             ex_taken;
    word_t            ex_target;
    logic             ex_pred_taken;
    word_t            ex_pred_target;
    logic [IDX_W-1:0] ex_index;
    logic             q_full;
    logic             flush;
    word_t            redirect_pc;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    word_t            upd_tag;
    word_t            upd_target;
    logic             upd_taken;
    logic             upd_ready;
    logic             init_busy;
    word_t            mispred_cnt;

    modport slave (
        input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken,
               ex_pred_target, ex_index, upd_ready,
        output q_full, flush, redirect_pc, upd_valid, upd_index, upd_tag,
               upd_target, upd_taken, init_busy, mispred_cnt
    );

    modport master (
        output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken,
               ex_pred_target, ex_index, upd_ready,
        input  q_full, flush, redirect_pc, upd_valid, upd_index, upd_tag,
               upd_target, upd_taken, init_busy, mispred_cnt
    );

endinterface

// File: rtl/br_resolve_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// br_upd_fifo
// Circular FIFO of predictor updates. Head is read combinationally so the
// controller can present it on the write port in the same cycle.
//   CLK, nRST  : clock, asynchronous active-low reset (empties the queue)
//   push/data  : write request; ignored while full, even with a pop
//   pop        : read request; ignored while empty
//   head       : entry at the read pointer
//   full/empty/count : occupancy
// ---------------------------------------------------------------------------
module br_upd_fifo
    import br_resolve_ctrl_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      push,
    input  br_upd_t                   push_data,
    input  logic                      pop,
    output br_upd_t                   head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int PTR_W = $clog2(QDEPTH);

    br_upd_t              mem [QDEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W:0]       count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_reg == (PTR_W+1)'(QDEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/br_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// br_resolve_ctrl
// Owns the branch predictor's write port. After reset it sweeps every entry
// to a cleared state (INIT), then (RUN) accepts EX resolutions, flags
// mispredicts with a one-cycle flush + redirect PC, and streams queued
// table updates into the predictor under upd_valid/upd_ready.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : br_resolve_ctrl_if.slave (EX inputs, predictor write port,
//               q_full stall, flush/redirect_pc, init_busy, mispred_cnt)
// ---------------------------------------------------------------------------
module br_resolve_ctrl
    import br_resolve_ctrl_pkg::*;
#(
    parameter int IDX_W  = 2,
    parameter int QDEPTH = 4
) (
    input  logic               CLK,
    input  logic               nRST,
    br_resolve_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    brc_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  sweep_reg, sweep_next;
    logic              flush_reg;
    word_t             redirect_reg;
    word_t             mispred_cnt_reg;

    br_upd_t           push_data;
    br_upd_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              q_full_int;
    logic              accept;
    logic              mispredict;

    assign mispredict = (bus.ex_taken != bus.ex_pred_taken) ||
                        (bus.ex_taken && (bus.ex_target != bus.ex_pred_target));
    assign accept     = bus.ex_valid && !q_full_int;

    assign push_data.index  = BRC_IDX_W_MAX'(bus.ex_index);
    assign push_data.tag    = bus.ex_pc;
    assign push_data.target = bus.ex_target;
    assign push_data.taken  = bus.ex_taken;

    br_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Index bits above IDX_W are always zero.
    generate
        if (IDX_W < BRC_IDX_W_MAX) begin : g_idx_hi
            logic idx_hi_unused;
            assign idx_hi_unused = |head.index[BRC_IDX_W_MAX-1:IDX_W];
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= INIT;
            sweep_reg       <= '0;
            flush_reg       <= 1'b0;
            redirect_reg    <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
            flush_reg <= accept && mispredict;
            // Holding redirect between flushes keeps it stable; only its
            // value during a flush pulse is meaningful.
            if (accept && mispredict) begin
                redirect_reg <= bus.ex_taken ? bus.ex_target
                                             : brc_fallthrough(bus.ex_pc);
                if (mispred_cnt_reg != '1)
                    mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_next     = sweep_reg;
        pop            = 1'b0;
        q_full_int     = (fifo_count == CNT_W'(QDEPTH));
        bus.init_busy  = 1'b0;
        bus.upd_valid  = 1'b0;
        bus.upd_index  = '0;
        bus.upd_tag    = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        case (state_reg)
            INIT: begin
                bus.init_busy = 1'b1;
                q_full_int    = 1'b1;
                // No predictor writes while reset is held.
                bus.upd_valid = nRST;
                bus.upd_index = sweep_reg;
                if (bus.upd_ready) begin
                    sweep_next = sweep_reg + 1'b1;
                    if (&sweep_reg)
                        state_next = RUN;
                end
            end
            RUN: begin
                bus.upd_valid  = !fifo_empty;
                bus.upd_index  = head.index[IDX_W-1:0];
                bus.upd_tag    = head.tag;
                bus.upd_target = head.target;
                bus.upd_taken  = head.taken;
                pop            = !fifo_empty && bus.upd_ready;
            end
            default: state_next = INIT;
        endcase
    end

    assign bus.q_full      = q_full_int;
    assign bus.flush       = flush_reg;
    assign bus.redirect_pc = redirect_reg;
    assign bus.mispred_cnt = mispred_cnt_reg;

endmodule
